// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches one word at a time over a
// req/ack memory handshake and presents PcP/Inst to the IF/ID register.
module fetch_unit #(
    parameter int              PC_W     = 16,
    parameter int              INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirectPc,
    output logic              imemReq,
    output logic [PC_W-1:0]   imemAddr,
    input  logic              imemAck,
    input  logic [INST_W-1:0] imemData,
    output logic              fetchValid,
    output logic [PC_W-1:0]   PcPOut,
    output logic [INST_W-1:0] InstOut
);

    // state   | meaning
    // START   | first cycle after reset, no request
    // FETCH   | request at pc outstanding
    // FULL    | output slot holds an instruction for IF/ID
    // DISCARD | stale request in flight after a redirect, data will be dropped
    typedef enum logic [1:0] {START, FETCH, FULL, DISCARD} state_t;

    state_t              state, state_n;
    logic [PC_W-1:0]     pc, pc_n;
    logic [PC_W-1:0]     req_addr, req_addr_n;
    logic                valid_n;
    logic [PC_W-1:0]     pcp_n;
    logic [INST_W-1:0]   inst_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= START;
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            fetchValid <= 1'b0;
            PcPOut     <= '0;
            InstOut    <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            req_addr   <= req_addr_n;
            fetchValid <= valid_n;
            PcPOut     <= pcp_n;
            InstOut    <= inst_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        req_addr_n = req_addr;
        valid_n    = fetchValid;
        pcp_n      = PcPOut;
        inst_n     = InstOut;
        case (state)
            START: begin
                state_n = FETCH;
                if (redirect) pc_n = redirectPc;
            end
            FETCH: begin
                if (imemAck) begin
                    if (redirect) begin
                        pc_n = redirectPc;
                    end else begin
                        pcp_n   = pc + 1'b1;
                        inst_n  = imemData;
                        valid_n = 1'b1;
                        pc_n    = pc + 1'b1;
                        state_n = FULL;
                    end
                end else if (redirect) begin
                    // address must stay on the bus until the memory answers
                    req_addr_n = pc;
                    pc_n       = redirectPc;
                    state_n    = DISCARD;
                end
            end
            FULL: begin
                if (redirect) begin
                    valid_n = 1'b0;
                    pc_n    = redirectPc;
                    state_n = FETCH;
                end else if (!stall) begin
                    valid_n = 1'b0;
                    state_n = FETCH;
                end
            end
            DISCARD: begin
                if (redirect) pc_n = redirectPc;
                if (imemAck) state_n = FETCH;
            end
            default: state_n = START;
        endcase
    end

    assign imemReq  = (state == FETCH) || (state == DISCARD);
    assign imemAddr = (state == DISCARD) ? req_addr : pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small latency-programmable memory responder.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirectPc;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        fetchValid;
    logic [15:0] PcPOut;
    logic [31:0] InstOut;

    int total = 0;
    int bad   = 0;
    int wait_cnt = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirectPc(redirectPc), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemAck(imemAck), .imemData(imemData), .fetchValid(fetchValid),
        .PcPOut(PcPOut), .InstOut(InstOut)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [15:0] a);
        return {16'hC0DE, a ^ 16'h5A5A};
    endfunction

    // ack is raised once the request has waited lat cycles without one
    task automatic drive_mem(input int lat);
        if (imemReq) begin
            if (wait_cnt >= lat) begin
                imemAck  = 1'b1;
                imemData = inst_of(imemAddr);
                wait_cnt = 0;
            end else begin
                imemAck  = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            imemAck  = 1'b0;
            wait_cnt = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int lat);
        drive_mem(lat);
        tick();
    endtask

    task automatic restart_at(input logic [15:0] a);
        rst = 1'b1; redirect = 1'b0; stall = 1'b0; imemAck = 1'b0;
        tick();
        rst = 1'b0; redirect = 1'b1; redirectPc = a;
        step(0);
        redirect = 1'b0;
        wait_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPc = '0;
        imemAck = 1'b0; imemData = '0;
        tick(); tick();
        rst = 1'b0;
        total++; if (imemReq !== 1'b0) begin bad++; $display("FAIL reset_req got=%h exp=0", imemReq); end
        total++; if (fetchValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%h exp=0", fetchValid); end
        total++; if (PcPOut !== 16'h0000) begin bad++; $display("FAIL reset_pcp got=%h exp=0000", PcPOut); end
        total++; if (InstOut !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h exp=0", InstOut); end
        total++; if (imemAddr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h exp=0000", imemAddr); end
        step(0);
        total++; if (imemReq !== 1'b1 || imemAddr !== 16'h0000) begin bad++; $display("FAIL first_req got=%h/%h exp=1/0000", imemReq, imemAddr); end
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 3; i++) begin
            step(0);
            total++; if (fetchValid !== 1'b1 || imemReq !== 1'b0) begin bad++; $display("FAIL zw_full%0d got=%h/%h exp=1/0", i, fetchValid, imemReq); end
            total++; if (PcPOut !== 16'(i + 1)) begin bad++; $display("FAIL zw_pcp%0d got=%h exp=%h", i, PcPOut, 16'(i + 1)); end
            total++; if (InstOut !== inst_of(16'(i))) begin bad++; $display("FAIL zw_inst%0d got=%h exp=%h", i, InstOut, inst_of(16'(i))); end
            step(0);
            total++; if (imemReq !== 1'b1 || imemAddr !== 16'(i + 1) || fetchValid !== 1'b0) begin
                bad++; $display("FAIL zw_req%0d got=%h/%h/%h exp=1/%h/0", i, imemReq, imemAddr, fetchValid, 16'(i + 1));
            end
        end
    endtask

    task automatic test_stall();
        step(0); step(0); step(0);
        total++; if (PcPOut !== 16'h0005 || fetchValid !== 1'b1) begin bad++; $display("FAIL stall_setup got=%h/%h exp=0005/1", PcPOut, fetchValid); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0);
            total++; if (imemReq !== 1'b0 || fetchValid !== 1'b1 || PcPOut !== 16'h0005 || InstOut !== inst_of(16'h0004)) begin
                bad++; $display("FAIL stall_hold%0d got=%h/%h/%h/%h exp=0/1/0005/%h", i, imemReq, fetchValid, PcPOut, InstOut, inst_of(16'h0004));
            end
        end
        stall = 1'b0;
        step(0);
        total++; if (imemReq !== 1'b1 || imemAddr !== 16'h0005 || fetchValid !== 1'b0) begin
            bad++; $display("FAIL stall_release got=%h/%h/%h exp=1/0005/0", imemReq, imemAddr, fetchValid);
        end
    endtask

    task automatic test_discard();
        restart_at(16'h0010);
        total++; if (imemReq !== 1'b1 || imemAddr !== 16'h0010) begin bad++; $display("FAIL dis_start got=%h/%h exp=1/0010", imemReq, imemAddr); end
        step(3);
        redirect = 1'b1; redirectPc = 16'h0040;
        step(3);
        redirect = 1'b0;
        total++; if (imemReq !== 1'b1 || imemAddr !== 16'h0010 || fetchValid !== 1'b0) begin
            bad++; $display("FAIL dis_enter got=%h/%h/%h exp=1/0010/0", imemReq, imemAddr, fetchValid);
        end
        step(3);
        total++; if (imemReq !== 1'b1 || imemAddr !== 16'h0010 || fetchValid !== 1'b0) begin
            bad++; $display("FAIL dis_hold got=%h/%h/%h exp=1/0010/0", imemReq, imemAddr, fetchValid);
        end
        step(3);
        total++; if (imemAddr !== 16'h0040 || imemReq !== 1'b1 || fetchValid !== 1'b0) begin
            bad++; $display("FAIL dis_exit got=%h/%h/%h exp=0040/1/0", imemAddr, imemReq, fetchValid);
        end
        step(0);
        total++; if (fetchValid !== 1'b1 || PcPOut !== 16'h0041 || InstOut !== inst_of(16'h0040)) begin
            bad++; $display("FAIL dis_next got=%h/%h/%h exp=1/0041/%h", fetchValid, PcPOut, InstOut, inst_of(16'h0040));
        end
    endtask

    task automatic test_discard_reredirect();
        restart_at(16'h0010);
        step(3);
        redirect = 1'b1; redirectPc = 16'h0040;
        step(3);
        redirectPc = 16'h0050;
        step(3);
        redirect = 1'b0;
        total++; if (imemAddr !== 16'h0010 || imemReq !== 1'b1) begin bad++; $display("FAIL redis_hold got=%h/%h exp=0010/1", imemAddr, imemReq); end
        step(3);
        total++; if (imemAddr !== 16'h0050 || fetchValid !== 1'b0) begin bad++; $display("FAIL redis_exit got=%h/%h exp=0050/0", imemAddr, fetchValid); end
    endtask

    task automatic test_redirect_ack();
        restart_at(16'h0008);
        redirect = 1'b1; redirectPc = 16'h0020;
        step(0);
        redirect = 1'b0;
        total++; if (fetchValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 16'h0020) begin
            bad++; $display("FAIL rack_drop got=%h/%h/%h exp=0/1/0020", fetchValid, imemReq, imemAddr);
        end
        step(0);
        total++; if (fetchValid !== 1'b1 || PcPOut !== 16'h0021 || InstOut !== inst_of(16'h0020)) begin
            bad++; $display("FAIL rack_next got=%h/%h/%h exp=1/0021/%h", fetchValid, PcPOut, InstOut, inst_of(16'h0020));
        end
    endtask

    task automatic test_redirect_full_stall();
        stall = 1'b1; redirect = 1'b1; redirectPc = 16'h0030;
        step(0);
        stall = 1'b0; redirect = 1'b0;
        total++; if (fetchValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 16'h0030) begin
            bad++; $display("FAIL rfull_redir got=%h/%h/%h exp=0/1/0030", fetchValid, imemReq, imemAddr);
        end
        total++; if (PcPOut !== 16'h0021) begin bad++; $display("FAIL rfull_pcp_kept got=%h exp=0021", PcPOut); end
    endtask

    task automatic test_wrap();
        restart_at(16'hFFFF);
        step(0);
        total++; if (fetchValid !== 1'b1 || PcPOut !== 16'h0000 || InstOut !== inst_of(16'hFFFF)) begin
            bad++; $display("FAIL wrap_pcp got=%h/%h/%h exp=1/0000/%h", fetchValid, PcPOut, InstOut, inst_of(16'hFFFF));
        end
        step(0);
        total++; if (imemAddr !== 16'h0000 || imemReq !== 1'b1) begin bad++; $display("FAIL wrap_addr got=%h/%h exp=0000/1", imemAddr, imemReq); end
    endtask

    task automatic test_reset_mid();
        step(0);
        step(0);
        step(0);
        total++; if (fetchValid !== 1'b1 || PcPOut !== 16'h0002) begin bad++; $display("FAIL rmid_setup got=%h/%h exp=1/0002", fetchValid, PcPOut); end
        step(0);
        rst = 1'b1;
        step(5);
        total++; if (imemReq !== 1'b0 || fetchValid !== 1'b0 || imemAddr !== 16'h0000) begin
            bad++; $display("FAIL rmid_reset got=%h/%h/%h exp=0/0/0000", imemReq, fetchValid, imemAddr);
        end
        rst = 1'b0;
        imemAck = 1'b1; imemData = 32'hDEADBEEF;
        tick();
        total++; if (imemReq !== 1'b1 || imemAddr !== 16'h0000 || fetchValid !== 1'b0) begin
            bad++; $display("FAIL rmid_late_ack got=%h/%h/%h exp=1/0000/0", imemReq, imemAddr, fetchValid);
        end
        imemAck = 1'b0;
        step(0);
        total++; if (PcPOut !== 16'h0001 || InstOut !== inst_of(16'h0000)) begin
            bad++; $display("FAIL rmid_refetch got=%h/%h exp=0001/%h", PcPOut, InstOut, inst_of(16'h0000));
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_discard();
        test_discard_reredirect();
        test_redirect_ack();
        test_redirect_full_stall();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch front end that produces the PcP/Inst pair consumed by the IF/ID pipeline register. It owns the PC and issues word requests to the instruction memory over a req/ack handshake. It offers each fetched instruction to IF/ID with a valid/stall handshake and redirects the PC on a taken branch or jump. A redirect that lands while a memory request is in flight drops the stale data.

Parameters:
PC_W, 16, PC and address width
INST_W, 32, instruction width
RESET_PC, 16'h0000, first fetch address after reset

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
stall  in  1  IF/ID cannot load this cycle (hazard unit)
redirect  in  1  taken branch/jump, one-cycle pulse
redirectPc  in  PC_W  target PC, sampled when redirect=1
imemReq  out  1  memory request
imemAddr  out  PC_W  word address for the request
imemAck  in  1  memory data valid, meaningful only while imemReq=1
imemData  in  INST_W  instruction word, sampled when imemAck=1
fetchValid  out  1  PcPOut/InstOut hold an instruction for IF/ID (IF/ID load = fetchValid & ~stall)
PcPOut  out  PC_W  fetched PC + 1
InstOut  out  INST_W  fetched instruction

Behaviour:
- Word-addressed memory; PC increments by 1, modulo 2^PC_W (0xFFFF -> 0x0000).
- States: START, FETCH, FULL, DISCARD.
- imemReq = 1 in FETCH or DISCARD, else 0.
- imemAddr = pc in FETCH; in DISCARD it holds the old in-flight address.
- Register state is reset when rst=1 at a clock edge:
  - state=START, pc=RESET_PC, fetchValid=0, PcPOut=0, InstOut=0.
  - imemReq is therefore 0 in the cycle after reset.
- Handshake rules:
  - Once imemReq rises, it and imemAddr stay stable until imemAck is sampled. There is no abort.
  - imemAck may arrive in the same cycle imemReq is first high (zero-wait memory).
- START: -> FETCH unconditionally. A redirect here loads pc <= redirectPc.
- FETCH:
  - ack & ~redirect: PcPOut <= imemAddr+1, InstOut <= imemData, fetchValid <= 1, pc <= pc+1; -> FULL.
  - ack & redirect: data dropped, pc <= redirectPc; stay FETCH.
  - ~ack & redirect: pc <= redirectPc; -> DISCARD.
  - ~ack & ~redirect: stay.
- FULL (imemReq=0; outputs held stable):
  - redirect: fetchValid <= 0, pc <= redirectPc; -> FETCH. Redirect has priority over stall and over acceptance.
  - ~stall: the instruction is accepted this cycle; fetchValid <= 0; -> FETCH.
  - stall: hold everything.
- DISCARD (imemReq=1 with the old address):
  - ack: data dropped; -> FETCH with pc = latest redirect target.
  - redirect with or without ack: pc <= redirectPc; a redirect without ack stays in DISCARD.
  - fetchValid=0 throughout.
- Throughput: at most one instruction per 2 cycles (FETCH/FULL alternation). No prefetch; single-entry output slot.
- PcPOut/InstOut change only on entry to FULL. They are not cleared by redirect; fetchValid gates them.
- rst mid-request: the request is abandoned in the cycle after reset (imemReq=0). Memory must tolerate this; a late ack while imemReq=0 is ignored.

Test Plan:
- Reset with RESET_PC=0, zero-wait memory (ack=req), stall=0 -> imemReq=0 first cycle. Addresses 0,1,2 issued every other cycle. fetchValid pulses show PcPOut=1,2,3 with InstOut=mem[0..2].
- stall=1 for 3 cycles while FULL holding PcPOut=5 -> imemReq=0, PcPOut=5 and InstOut stable, fetchValid=1. Next request (addr 5) issues the cycle after stall drops.
- 3-cycle memory latency, redirect to 0x0040 one cycle after req to addr 0x0010 -> state DISCARD, imemAddr stays 0x0010 until ack. Ack data never appears, fetchValid stays 0. Next imemAddr=0x0040.
- Redirect to 0x0020 in the same cycle as ack for addr 0x0008 -> no fetchValid pulse. Next imemAddr=0x0020.
- Redirect to 0x0030 while FULL and stall=1 -> fetchValid=0 next cycle, imemAddr=0x0030.
- PC=0xFFFF fetched -> PcPOut=0x0000, next imemAddr=0x0000. rst asserted mid-request -> imemReq=0, fetchValid=0, imemAddr=RESET_PC after the edge.
